ide_cycle_sequencer: RTL and testbench

Sequences individual IDE PIO transfers for the Zorro II IDE window. Once the address decode flags an IDE hit, it generates IOR_n/IOW_n with programmable setup, active and recovery times, honours drive IORDY with a timeout, and returns a bus-cycle acknowledge. It sits between the autoconfig/address-decode logic, which supplies `ide_access` and the configuration writes, and the IDE connector strobes. It runs on the 7 MHz bus clock.

---
 rtl/ide_cycle_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_ide_cycle_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ide_cycle_sequencer.sv
// ide_cycle_sequencer
//
// Generates one IDE PIO strobe per Zorro II bus cycle that hits the IDE
// window. The strobe is framed by programmable setup, active and recovery
// times, can be stretched by the drive through IORDY (bounded by a timeout),
// and is answered with a bus acknowledge that holds until AS_n is released.
//
// Ports
//   CLK         7 MHz bus clock, rising edge
//   RESET       asynchronous, active-high reset
//   AS_n        68000 address strobe, active low
//   RW          bus direction, 1 = read
//   UDS_n/LDS_n data strobes, active low
//   ide_access  decoded IDE register hit
//   IORDY       drive ready; low stretches the active phase
//   cfg_wr      one-cycle load strobe for the timing register
//   cfg_din     [1:0] setup S, [4:2] active-1 A, [7:5] recovery R
//   IOR_n/IOW_n registered IDE read/write strobes
//   DTACK       active-high acknowledge toward the bus DTACK driver
//   busy        high whenever a transfer or its recovery is in progress
//   timeout     sticky flag, set when an IORDY stretch hits its limit
module ide_cycle_sequencer #(
  parameter logic [7:0] CFG_DEFAULT   = 8'h49,
  parameter int         IORDY_TIMEOUT = 255
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       AS_n,
  input  logic       RW,
  input  logic       UDS_n,
  input  logic       LDS_n,
  input  logic       ide_access,
  input  logic       IORDY,
  input  logic       cfg_wr,
  input  logic [7:0] cfg_din,
  output logic       IOR_n,
  output logic       IOW_n,
  output logic       DTACK,
  output logic       busy,
  output logic       timeout
);

  localparam int EXT_W = (IORDY_TIMEOUT < 2) ? 1 : $clog2(IORDY_TIMEOUT + 1);
  localparam logic [EXT_W-1:0] EXT_MAX = EXT_W'(IORDY_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ACTIVE, S_ACK, S_RECOVER
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       cfg_q, cfg_d;
  logic [2:0]       act_q, act_d;     // active count snapshot (cycles - 1)
  logic [2:0]       rec_q, rec_d;     // recovery count snapshot
  logic [2:0]       cnt_q, cnt_d;     // down-counter for the current phase
  logic [EXT_W-1:0] ext_q, ext_d;     // IORDY stretch cycles taken so far
  logic             dir_q, dir_d;     // 1 = read transfer
  logic             ior_n_q, ior_n_d;
  logic             iow_n_q, iow_n_d;
  logic             dtack_q, dtack_d;
  logic             timeout_q, timeout_d;

  logic             start;
  logic             expire;

  assign start = !AS_n && ide_access && (!UDS_n || !LDS_n);

  // NOTE: every variable assigned here gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    act_d     = act_q;
    rec_d     = rec_q;
    cnt_d     = cnt_q;
    ext_d     = ext_q;
    dir_d     = dir_q;
    timeout_d = timeout_q;
    expire    = 1'b0;

    if (cfg_wr) cfg_d = cfg_din;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Snapshot now so a later cfg_wr cannot disturb this transfer.
          act_d = cfg_q[4:2];
          rec_d = cfg_q[7:5];
          dir_d = RW;
          ext_d = '0;
          if (cfg_q[1:0] != 2'd0) begin
            state_d = S_SETUP;
            cnt_d   = {1'b0, cfg_q[1:0]};
          end else begin
            state_d = S_ACTIVE;
            cnt_d   = cfg_q[4:2];
          end
        end
      end

      S_SETUP: begin
        if (AS_n) begin
          state_d = S_IDLE;
        end else if (cnt_q <= 3'd1) begin
          state_d = S_ACTIVE;
          cnt_d   = act_q;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      S_ACTIVE: begin
        if (AS_n) begin
          // Aborted transfer: drop the strobe, still honour recovery.
          if (rec_q != 3'd0) begin
            state_d = S_RECOVER;
            cnt_d   = rec_q;
          end else begin
            state_d = S_IDLE;
          end
        end else if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else if (IORDY) begin
          state_d = S_ACK;
        end else if (ext_q == EXT_MAX) begin
          state_d = S_ACK;
          expire  = 1'b1;
        end else begin
          ext_d = ext_q + EXT_W'(1);
        end
      end

      S_ACK: begin
        if (AS_n) begin
          if (rec_q != 3'd0) begin
            state_d = S_RECOVER;
            cnt_d   = rec_q;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_RECOVER: begin
        if (cnt_q <= 3'd1) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 3'd1;
      end

      default: state_d = S_IDLE;
    endcase

    // Expiry is applied after the clear so a coincident cfg_wr leaves it set.
    if (cfg_wr) timeout_d = 1'b0;
    if (expire) timeout_d = 1'b1;

    // Outputs are decoded from the next state so they switch on the same
    // edge as the state they belong to.
    ior_n_d = !((state_d == S_ACTIVE) && dir_d);
    iow_n_d = !((state_d == S_ACTIVE) && !dir_d);
    dtack_d = (state_d == S_ACK);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge values of the others, independent of statement order.
  // NOTE: the timing register has a reset value, unlike a RAM, because the
  // first transfer after reset must already run with valid timing.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      cfg_q     <= CFG_DEFAULT;
      act_q     <= 3'd0;
      rec_q     <= 3'd0;
      cnt_q     <= 3'd0;
      ext_q     <= '0;
      dir_q     <= 1'b0;
      ior_n_q   <= 1'b1;
      iow_n_q   <= 1'b1;
      dtack_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      act_q     <= act_d;
      rec_q     <= rec_d;
      cnt_q     <= cnt_d;
      ext_q     <= ext_d;
      dir_q     <= dir_d;
      ior_n_q   <= ior_n_d;
      iow_n_q   <= iow_n_d;
      dtack_q   <= dtack_d;
      timeout_q <= timeout_d;
    end
  end

  assign IOR_n   = ior_n_q;
  assign IOW_n   = iow_n_q;
  assign DTACK   = dtack_q;
  assign timeout = timeout_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_ide_cycle_sequencer.sv
// Directed testbench for ide_cycle_sequencer. Edge 0 is the rising edge that
// samples the start condition; outputs are sampled 1 ns after each edge.
module tb_ide_cycle_sequencer;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       AS_n, RW, UDS_n, LDS_n, ide_access, IORDY, cfg_wr;
  logic [7:0] cfg_din;
  logic       IOR_n, IOW_n, DTACK, busy, timeout;

  int vectors     = 0;
  int miscompares = 0;

  ide_cycle_sequencer dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .AS_n       (AS_n),
    .RW         (RW),
    .UDS_n      (UDS_n),
    .LDS_n      (LDS_n),
    .ide_access (ide_access),
    .IORDY      (IORDY),
    .cfg_wr     (cfg_wr),
    .cfg_din    (cfg_din),
    .IOR_n      (IOR_n),
    .IOW_n      (IOW_n),
    .DTACK      (DTACK),
    .busy       (busy),
    .timeout    (timeout)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_cfg(input logic [7:0] val);
    cfg_wr  = 1'b1;
    cfg_din = val;
    tick();
    cfg_wr  = 1'b0;
  endtask

  task automatic release_as();
    AS_n  = 1'b1;
    UDS_n = 1'b1;
    LDS_n = 1'b1;
  endtask

  // Starts a transfer and runs until DTACK or the budget. Optionally raises
  // IORDY before edge iordy_rel and pulses cfg_wr on edge cfg_edge.
  task automatic run_cycle(input logic rw, input int iordy_rel, input int cfg_edge,
                           input logic [7:0] cfg_val, input int budget,
                           output int first_low, output int low_cnt,
                           output int ack_edge, output int wrong_low);
    logic sel, oth;
    AS_n = 1'b0; RW = rw; UDS_n = !rw; LDS_n = rw; ide_access = 1'b1;
    first_low = -1; low_cnt = 0; ack_edge = -1; wrong_low = 0;
    for (int e = 0; e <= budget; e++) begin
      tick();
      cfg_wr = 1'b0;
      sel = rw ? IOR_n : IOW_n;
      oth = rw ? IOW_n : IOR_n;
      if (!sel) begin
        low_cnt++;
        if (first_low < 0) first_low = e;
      end
      if (!oth) wrong_low++;
      if (DTACK) begin
        ack_edge = e;
        break;
      end
      if (e + 1 == iordy_rel) IORDY = 1'b1;
      if (e + 1 == cfg_edge) begin
        cfg_wr  = 1'b1;
        cfg_din = cfg_val;
      end
    end
  endtask

  initial begin
    int fl, lc, ae, wl, drop_e, low_e;

    RESET = 1'b1; AS_n = 1'b1; RW = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1;
    ide_access = 1'b0; IORDY = 1'b1; cfg_wr = 1'b0; cfg_din = 8'h00;
    #12;
    check("rst_ior_n", IOR_n, 1);
    check("rst_iow_n", IOW_n, 1);
    check("rst_dtack", DTACK, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout, 0);
    RESET = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // Default config read: S=1, A=2, R=2.
    run_cycle(1'b1, -1, -1, 8'h00, 20, fl, lc, ae, wl);
    check("t1_first_low", fl, 1);
    check("t1_low_cnt", lc, 3);
    check("t1_ack_edge", ae, 4);
    check("t1_iow_low", wl, 0);
    tick();
    check("t1_dtack_hold", DTACK, 1);
    check("t1_busy_hold", busy, 1);
    release_as();
    tick();
    check("t1_dtack_drop", DTACK, 0);
    check("t1_busy_n", busy, 1);
    tick();
    check("t1_busy_n1", busy, 1);
    tick();
    check("t1_busy_n2", busy, 0);

    // All-zero timing, write: strobe during edge 0..1 only, no recovery.
    write_cfg(8'h00);
    run_cycle(1'b0, -1, -1, 8'h00, 20, fl, lc, ae, wl);
    check("t2_first_low", fl, 0);
    check("t2_low_cnt", lc, 1);
    check("t2_ack_edge", ae, 1);
    check("t2_ior_low", wl, 0);
    release_as();
    tick();
    check("t2_dtack_drop", DTACK, 0);
    check("t2_busy_drop", busy, 0);

    // IORDY low for 10 cycles past the nominal active end.
    write_cfg(8'h49);
    IORDY = 1'b0;
    run_cycle(1'b1, 14, -1, 8'h00, 40, fl, lc, ae, wl);
    check("t3_first_low", fl, 1);
    check("t3_low_cnt", lc, 13);
    check("t3_ack_edge", ae, 14);
    check("t3_timeout", timeout, 0);
    release_as();
    tick(); tick(); tick();
    check("t3_busy_drop", busy, 0);

    // IORDY stuck low: timeout after 255 stretches; cfg_wr on the expiry
    // edge must not win over the expiry.
    IORDY = 1'b0;
    run_cycle(1'b1, -1, 259, 8'h49, 300, fl, lc, ae, wl);
    check("t4_low_cnt", lc, 258);
    check("t4_ack_edge", ae, 259);
    check("t4_timeout_set", timeout, 1);
    check("t4_dtack", DTACK, 1);
    IORDY = 1'b1;
    release_as();
    tick(); tick(); tick();
    check("t4_timeout_sticky", timeout, 1);
    write_cfg(8'h49);
    check("t4_timeout_clr", timeout, 0);

    // Abort during SETUP with S=3, A=2, R=2.
    write_cfg(8'h4B);
    AS_n = 1'b0; RW = 1'b1; UDS_n = 1'b0; LDS_n = 1'b1; ide_access = 1'b1;
    tick();
    check("t5_busy_e0", busy, 1);
    tick();
    check("t5_ior_e1", IOR_n, 1);
    release_as();
    tick();
    check("t5_abort_busy", busy, 0);
    check("t5_abort_ior", IOR_n, 1);
    check("t5_abort_dtack", DTACK, 0);

    // Abort in the middle of ACTIVE.
    AS_n = 1'b0; UDS_n = 1'b0;
    tick(); tick(); tick(); tick();
    check("t6_ior_e3", IOR_n, 0);
    tick();
    check("t6_ior_e4", IOR_n, 0);
    release_as();
    tick();
    check("t6_ior_rel", IOR_n, 1);
    check("t6_dtack", DTACK, 0);
    check("t6_busy_rec", busy, 1);
    tick();
    check("t6_busy_rec1", busy, 1);
    tick();
    check("t6_busy_idle", busy, 0);

    // R=7, S=0, A=0; cfg_wr of 8'h00 mid-cycle must not shorten recovery.
    write_cfg(8'hE0);
    run_cycle(1'b1, -1, 1, 8'h00, 20, fl, lc, ae, wl);
    check("t7_first_low", fl, 0);
    check("t7_ack_edge", ae, 1);
    release_as();
    tick();
    check("t7_dtack_drop", DTACK, 0);
    AS_n = 1'b0; UDS_n = 1'b0;
    drop_e = -1; low_e = -1;
    for (int e = 3; e <= 25; e++) begin
      tick();
      if (!busy && drop_e < 0) drop_e = e;
      if (!IOR_n) begin
        low_e = e;
        break;
      end
    end
    check("t7_idle_edge", drop_e, 9);
    check("t7_restart_edge", low_e, 10);
    tick();
    check("t7_dtack2", DTACK, 1);
    check("t7_ior2", IOR_n, 1);
    release_as();
    tick();
    check("t7_busy2", busy, 0);

    // Asynchronous reset while IOW_n is low.
    IORDY = 1'b0;
    AS_n = 1'b0; RW = 1'b0; UDS_n = 1'b1; LDS_n = 1'b0;
    tick();
    check("t8_iow_e0", IOW_n, 0);
    tick(); tick();
    check("t8_iow_e2", IOW_n, 0);
    #2 RESET = 1'b1;
    #1;
    check("t8_rst_iow", IOW_n, 1);
    check("t8_rst_dtack", DTACK, 0);
    check("t8_rst_busy", busy, 0);
    release_as();
    IORDY = 1'b1;
    #1 RESET = 1'b0;
    // Timing register must be back at the default.
    run_cycle(1'b1, -1, -1, 8'h00, 20, fl, lc, ae, wl);
    check("t8_first_low", fl, 1);
    check("t8_low_cnt", lc, 3);
    check("t8_ack_edge", ae, 4);
    release_as();
    tick(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
